// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err0;
  logic          err1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-ported data memory.
// One access per three cycles: IDLE (grant) -> ACCESS (memory strobe) -> RESP (ack).
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 18,
  parameter int unsigned DW    = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          cmd_id_q, cmd_id_d;
  logic          cmd_we_q, cmd_we_d;
  logic          cmd_oor_q, cmd_oor_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_write_q, mem_write_d;
  logic          mem_read_q, mem_read_d;

  // Winner selection: a lone requester wins, otherwise the pointer decides.
  logic          win_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          sel_oor_c;

  assign win_c       = bus.req1 & (~bus.req0 | ptr_q);
  assign sel_we_c    = win_c ? bus.we1    : bus.we0;
  assign sel_addr_c  = win_c ? bus.addr1  : bus.addr0;
  assign sel_wdata_c = win_c ? bus.wdata1 : bus.wdata0;
  assign sel_oor_c   = (sel_addr_c >= AW'(DEPTH));

  // State and registered outputs; reset also kills an in-flight memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_oor_q   <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_oor_q   <= cmd_oor_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req0 | bus.req1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; memory strobes are live only in ACCESS.
  always_comb begin
    ptr_d       = ptr_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_oor_d   = cmd_oor_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          cmd_id_d    = win_c;
          cmd_we_d    = sel_we_c;
          cmd_oor_d   = sel_oor_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_write_d = sel_we_c & ~sel_oor_c;
          mem_read_d  = ~sel_we_c & ~sel_oor_c;
        end
      end
      ACCESS: begin
        ptr_d = ~cmd_id_q;
        if (cmd_id_q) begin
          ack1_d = 1'b1;
          err1_d = cmd_oor_q;
          if (!cmd_we_q) rdata1_d = cmd_oor_q ? '0 : bus.mem_rdata;
        end else begin
          ack0_d = 1'b1;
          err0_d = cmd_oor_q;
          if (!cmd_we_q) rdata0_d = cmd_oor_q ? '0 : bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_read  = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level memory/round-robin model feeds an expected
// queue; a negedge monitor pops and compares on every ack.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Attached memory: combinational read, write on rising edge, bench preload port.
  logic [DW-1:0] mem [DEPTH];
  logic          pre_we   = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign bus.mem_rdata = (bus.mem_addr < AW'(DEPTH)) ? mem[bus.mem_addr[7:0]] : '0;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    else if (pre_we)   mem[pre_addr] <= pre_data;
  end

  typedef struct {
    bit            port;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_ptr = 1'b0;
  logic [DW-1:0] ref_rd [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one served transaction, in service order.
  function automatic void model_serve(input bit p, input bit we, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d);
    exp_t e;
    e.port = p;
    e.err  = (a >= AW'(DEPTH));
    if (e.err) begin
      if (!we) ref_rd[p] = '0;
    end else if (we) begin
      ref_mem[a[7:0]] = d;
    end else begin
      ref_rd[p] = ref_mem[a[7:0]];
    end
    e.rdata = ref_rd[p];
    ref_ptr = ~p;
    exp_q.push_back(e);
  endfunction

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit            ord [2];
    bit            cw  [2];
    logic [AW-1:0] ca  [2];
    logic [DW-1:0] cd  [2];
    int            n, got, cyc;
    cw[0] = w0; cw[1] = w1; ca[0] = a0; ca[1] = a1; cd[0] = d0; cd[1] = d1;
    if (r0 && r1) begin
      ord[0] = ref_ptr; ord[1] = ~ref_ptr; n = 2;
    end else begin
      ord[0] = r1; ord[1] = 1'b0; n = 1;
    end
    for (int k = 0; k < n; k++) model_serve(ord[k], cw[ord[k]], ca[ord[k]], cd[ord[k]]);
    @(negedge clk);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    got = 0; cyc = 0;
    while (got < n && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < n; k++) begin
        bit p;
        bit oor;
        p   = ord[k];
        oor = (ca[p] >= AW'(DEPTH));
        if (cyc == 3*k + 1)
          check("access_strobe",
                128'({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata}),
                128'({cw[p] & ~oor, ~cw[p] & ~oor, ca[p], cd[p]}));
        if (cyc == 3*k + 2) begin
          check("resp_mem_idle",
                128'({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata}), 128'(0));
          check("ack_time", 128'({bus.ack1, bus.ack0}), 128'(p ? 2'b10 : 2'b01));
        end
      end
      if (bus.ack0 && bus.req0) begin bus.req0 = 1'b0; got++; end
      if (bus.ack1 && bus.req1) begin bus.req1 = 1'b0; got++; end
    end
    if (got < n) begin
      check("round_timeout", 128'(got), 128'(n));
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every ack must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.mem_write || bus.mem_read)
        check("mem_strobe_legal",
              128'({bus.mem_write & bus.mem_read, bus.mem_addr >= AW'(DEPTH)}), 128'(0));
      if (bus.ack0 || bus.ack1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 128'({bus.ack1, bus.ack0}), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 128'({bus.ack1, bus.ack0}), 128'(e.port ? 2'b10 : 2'b01));
          check("rdata", 128'(e.port ? bus.rdata1 : bus.rdata0), 128'(e.rdata));
          check("err", 128'({bus.err1, bus.err0}),
                128'(e.err ? (e.port ? 2'b10 : 2'b01) : 2'b00));
        end
      end
    end
  end

  initial begin
    int t_ack [3];
    int na, cyc, nmis;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    ref_rd[0] = '0; ref_rd[1] = '0;

    // Clear memory while reset is held.
    pre_we = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pre_addr = 8'(i); pre_data = '0; ref_mem[i] = '0;
      @(negedge clk);
    end
    pre_we = 1'b0;
    preload(8'd10, 32'hA0A0_0010);
    preload(8'd20, 32'hB0B0_0020);

    check("reset_outputs",
          128'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1,
                bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata}), 128'(0));

    // Both ports requesting continuously out of reset: grants 0,1,0.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 18'd10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 18'd20;
    ref_ptr = 1'b0;
    model_serve(1'b0, 1'b0, 18'd10, '0);
    model_serve(1'b1, 1'b0, 18'd20, '0);
    model_serve(1'b0, 1'b0, 18'd10, '0);
    @(negedge clk); rst_n = 1'b1;
    na = 0; cyc = 0; t_ack[0] = 0; t_ack[1] = 0; t_ack[2] = 0;
    while (na < 3 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        t_ack[na] = cyc;
        na++;
        if (na == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contention_ack_cycles", 128'({32'(t_ack[0]), 32'(t_ack[1]), 32'(t_ack[2])}),
          128'({32'd2, 32'd5, 32'd8}));
    @(posedge clk); #1;

    // Single read.
    preload(8'd5, 32'hDEAD_BEEF);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 18'd5, 18'd0, '0, '0);
    // Port 1 write then read of the top word.
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 18'd0, 18'd255, '0, 32'h1234_5678);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 18'd255, '0, '0);
    // Out-of-range write and read.
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 18'd256, 18'd0, 32'hFFFF_FFFF, '0);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 18'h3FFFF, '0, '0);
    // Simultaneous mixed write/read.
    run_round(1'b1, 1'b1, 1'b1, 1'b0, 18'd3, 18'd5, 32'h0303_0303, '0);

    // Reset during the ACCESS cycle of a write.
    preload(8'd7, '0);
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 18'd7; bus.wdata0 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("rst_access_write", 128'(bus.mem_write), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_write_drop", 128'(bus.mem_write), 128'(0));
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    check("rst_mem7_kept", 128'(mem[7]), 128'(0));
    check("rst_outputs",
          128'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1,
                bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata}), 128'(0));
    ref_ptr = 1'b0; ref_rd[0] = '0; ref_rd[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 18'd7, 18'd5, '0, '0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      bit r0, r1;
      logic [AW-1:0] a0, a1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      a0 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 262143)) : AW'($urandom_range(0, 255));
      a1 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 262143)) : AW'($urandom_range(0, 255));
      run_round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                a0, a1, DW'($urandom), DW'($urandom));
    end

    check("rdata_held", 128'({bus.rdata1, bus.rdata0}), 128'({ref_rd[1], ref_rd[0]}));
    nmis = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_contents", 128'(nmis), 128'(0));
    check("exp_queue_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
